// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the MEM-stage data-memory bridge: FSM encodings,
// counter width and the default error word returned on failed reads.
package dmem_bridge_pkg;

    typedef logic [1:0] dmb_state_t;

    localparam dmb_state_t DMB_IDLE  = 2'd0;
    localparam dmb_state_t DMB_REQ   = 2'd1;
    localparam dmb_state_t DMB_DRAIN = 2'd2;
    localparam dmb_state_t DMB_DONE  = 2'd3;

    localparam int          DMB_CNT_W            = 8;
    localparam logic [31:0] DMB_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Bus-wait cycle counter: cleared when a wait starts, counts while enabled,
// and flags expiry on the cycle the count reaches TIMEOUT-1.
module dmem_timeout_cnt
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [DMB_CNT_W-1:0] LIMIT = DMB_CNT_W'(TIMEOUT - 1);

    logic [DMB_CNT_W-1:0] cnt_q;
    logic [DMB_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_bridge.sv
// Turns the MEM stage's single-cycle word access into a req/ack bus
// transaction, stalling the pipeline and flagging misalign/timeout errors.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = DMB_ERR_DATA_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_adv,
    input  logic        mem_flush,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err_pulse,
    output logic        err_sticky
);

    dmb_state_t  state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] mem_din_q,   mem_din_d;
    logic        err_pulse_q, err_pulse_d;
    logic        err_sticky_q;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_expire;
    logic access;
    logic misaligned;

    assign access     = mem_ren | mem_wen;
    assign misaligned = (mem_addr[1:0] != 2'b00);

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expire_o (cnt_expire)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_din_d   = mem_din_q;
        err_pulse_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        mem_stall   = 1'b0;

        case (state_q)
            DMB_IDLE: begin
                if (access) begin
                    mem_stall = 1'b1;
                    if (misaligned) begin
                        mem_din_d   = ERR_DATA;
                        err_pulse_d = 1'b1;
                        state_d     = DMB_DONE;
                    end else begin
                        bus_we_d    = mem_wen;
                        bus_addr_d  = {mem_addr[31:2], 2'b00};
                        bus_wdata_d = mem_dout;
                        bus_req_d   = 1'b1;
                        cnt_clr     = 1'b1;
                        state_d     = DMB_REQ;
                    end
                end
            end

            DMB_REQ: begin
                mem_stall = 1'b1;
                cnt_en    = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        mem_din_d = bus_rdata;
                    end
                    state_d = DMB_DONE;
                end else if (cnt_expire) begin
                    bus_req_d   = 1'b0;
                    mem_din_d   = ERR_DATA;
                    err_pulse_d = 1'b1;
                    state_d     = DMB_DONE;
                end else if (mem_flush) begin
                    // The bus cycle is already in flight; let it finish unobserved.
                    cnt_clr = 1'b1;
                    state_d = DMB_DRAIN;
                end
            end

            DMB_DRAIN: begin
                cnt_en = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = DMB_IDLE;
                end else if (cnt_expire) begin
                    bus_req_d   = 1'b0;
                    err_pulse_d = 1'b1;
                    state_d     = DMB_IDLE;
                end
            end

            DMB_DONE: begin
                // Never re-issue from here: a pipeline held by another hazard keeps the same access up.
                if (mem_adv | mem_flush) begin
                    state_d = DMB_IDLE;
                end
            end

            default: begin
                state_d = DMB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments.
        if (rst) begin
            state_q      <= DMB_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            mem_din_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            mem_din_q    <= mem_din_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_q | err_pulse_q;
        end
    end

    assign mem_din    = mem_din_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed corner cases plus randomized
// accesses against a transaction-level model of the pipeline's view of memory.
module tb_dmem_bridge;

    localparam int          T   = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren, mem_wen, mem_adv, mem_flush;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err_pulse, err_sticky;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state and the bench's bus-side memory (kept separate).
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_din;
    logic        ref_sticky;

    logic        last_we;
    logic [31:0] last_addr, last_wdata;

    dmem_bridge #(
        .TIMEOUT  (T),
        .ERR_DATA (ERR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_adv    (mem_adv),
        .mem_flush  (mem_flush),
        .mem_din    (mem_din),
        .mem_stall  (mem_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1357;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] bus_read(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    task automatic drive_idle();
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_adv   = 1'b0;
        mem_flush = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    // Bus responder: acks on the ack_lat-th cycle that bus_req is seen high.
    task automatic drive_bus(input int ack_lat, inout int req_n);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        if (bus_req === 1'b1) begin
            req_n++;
            last_we    = bus_we;
            last_addr  = bus_addr;
            last_wdata = bus_wdata;
            if (req_n == ack_lat) begin
                bus_ack = 1'b1;
                if (bus_we) bus_mem[bus_addr] = bus_wdata;
                else        bus_rdata = bus_read(bus_addr);
            end
        end
    endtask

    task automatic run_access(input logic ren, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_lat, input int hold);
        logic        mis;
        logic [31:0] waddr;
        int          exp_req;
        logic [31:0] exp_din;
        logic        exp_err;
        int          req_n   = 0;
        int          stall_n = 0;
        int          err_n   = 0;
        int          cyc     = 0;
        logic        done    = 1'b0;
        logic [31:0] din_at_done = '0;

        mis   = (addr[1:0] != 2'b00);
        waddr = {addr[31:2], 2'b00};
        if (mis) begin
            exp_req = 0;
            exp_din = ERR;
            exp_err = 1'b1;
        end else if (ack_lat <= T) begin
            exp_req = ack_lat;
            exp_err = 1'b0;
            exp_din = wen ? ref_din : ref_read(waddr);
            if (wen) ref_mem[waddr] = wdata;
        end else begin
            exp_req = T;
            exp_din = ERR;
            exp_err = 1'b1;
        end
        ref_din    = exp_din;
        ref_sticky = ref_sticky | exp_err;

        while (!done && cyc < 400) begin
            @(negedge clk);
            mem_ren   = ren;
            mem_wen   = wen;
            mem_addr  = addr;
            mem_dout  = wdata;
            mem_adv   = 1'b0;
            mem_flush = 1'b0;
            drive_bus(ack_lat, req_n);
            #1;
            if (err_pulse) err_n++;
            if (mem_stall) stall_n++;
            else begin
                done        = 1'b1;
                din_at_done = mem_din;
            end
            cyc++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("din_at_done", din_at_done, exp_din);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            mem_adv = 1'b0;
            drive_bus(-1, req_n);
            #1;
            if (err_pulse) err_n++;
            if (mem_stall) stall_n++;
            check("din_hold", mem_din, exp_din);
        end

        @(negedge clk);
        mem_adv = 1'b1;
        drive_bus(-1, req_n);
        #1;
        if (err_pulse) err_n++;
        if (mem_stall) stall_n++;
        check("din_adv", mem_din, exp_din);
        check("err_sticky", 32'(err_sticky), 32'(ref_sticky));

        check("stall_cycles", 32'(stall_n), 32'(1 + exp_req));
        check("req_cycles", 32'(req_n), 32'(exp_req));
        check("err_pulses", 32'(err_n), 32'(exp_err));
        if (exp_req > 0) begin
            check("bus_we", 32'(last_we), 32'(wen));
            check("bus_addr", last_addr, waddr);
            if (wen) check("bus_wdata", last_wdata, wdata);
        end
    endtask

    task automatic run_flush(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input int flush_at, input int ack_lat);
        int   exp_req;
        logic exp_err;
        int   req_n   = 0;
        int   stall_n = 0;
        int   err_n   = 0;
        int   cyc     = 0;
        logic done    = 1'b0;

        if (ack_lat - flush_at <= T) begin
            exp_req = ack_lat;
            exp_err = 1'b0;
            if (wen) ref_mem[addr] = wdata;
        end else begin
            exp_req = flush_at + T;
            exp_err = 1'b1;
        end
        ref_sticky = ref_sticky | exp_err;

        while (!done && cyc < 400) begin
            @(negedge clk);
            if (cyc <= flush_at) begin
                mem_ren  = ~wen;
                mem_wen  = wen;
                mem_addr = addr;
                mem_dout = wdata;
            end else begin
                mem_ren = 1'b0;
                mem_wen = 1'b0;
            end
            mem_flush = (cyc == flush_at);
            mem_adv   = 1'b0;
            drive_bus(ack_lat, req_n);
            #1;
            if (mem_stall) stall_n++;
            if (err_pulse) err_n++;
            if (cyc > flush_at && !bus_req) done = 1'b1;
            cyc++;
        end
        check("flush_done_reached", 32'(done), 32'd1);

        @(negedge clk);
        drive_idle();
        #1;
        if (err_pulse) err_n++;
        check("flush_idle_stall", 32'(mem_stall), 32'd0);
        check("flush_stall_cycles", 32'(stall_n), 32'(1 + flush_at));
        check("flush_req_cycles", 32'(req_n), 32'(exp_req));
        check("flush_err_pulses", 32'(err_n), 32'(exp_err));
        check("flush_din_kept", mem_din, ref_din);
        check("flush_sticky", 32'(err_sticky), 32'(ref_sticky));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_req"},    32'(bus_req),    32'd0);
        check({tag, "_bus_we"},     32'(bus_we),     32'd0);
        check({tag, "_bus_addr"},   bus_addr,        32'd0);
        check({tag, "_bus_wdata"},  bus_wdata,       32'd0);
        check({tag, "_mem_din"},    mem_din,         32'd0);
        check({tag, "_err_pulse"},  32'(err_pulse),  32'd0);
        check({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
        check({tag, "_mem_stall"},  32'(mem_stall),  32'd0);
    endtask

    task automatic run_reset_mid();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ren   = 1'b1;
            mem_wen   = 1'b0;
            mem_addr  = 32'h0000_0040;
            mem_adv   = 1'b0;
            mem_flush = 1'b0;
            bus_ack   = 1'b0;
        end
        #1;
        check("pre_reset_bus_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        ref_din    = '0;
        ref_sticky = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        ref_din    = '0;
        ref_sticky = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed corner cases.
        ref_mem[32'h10] = 32'h1234_5678;
        bus_mem[32'h10] = 32'h1234_5678;
        run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0,          1,    0);
        run_access(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5,  3,    0);
        run_access(1'b1, 1'b0, 32'h0000_0020, 32'h0,          2,    1);
        run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0,          1,    0);
        run_access(1'b1, 1'b0, 32'h0000_0024, 32'h0,          1000, 0);
        run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0,          T,    0);
        run_access(1'b1, 1'b1, 32'h0000_0034, 32'h0BAD_F00D,  2,    5);
        run_access(1'b1, 1'b0, 32'h0000_0034, 32'h0,          1,    5);
        run_flush(1'b0, 32'h0000_0010, 32'h0,          2, 4);
        run_flush(1'b1, 32'h0000_0038, 32'hCAFE_0001,  1, 3);
        run_access(1'b1, 1'b0, 32'h0000_0038, 32'h0,          1,    0);
        run_flush(1'b0, 32'h0000_003C, 32'h0,          2, 1000);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            logic        r, w;
            logic [31:0] a;
            int          sel, lat, hold;
            sel = $urandom_range(0, 2);
            r   = (sel != 1);
            w   = (sel != 0);
            a   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            lat  = ($urandom_range(0, 9) == 0) ? T + 1 + $urandom_range(0, 3)
                                               : $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            run_access(r, w, a, $urandom, lat, hold);
        end

        run_reset_mid();
        run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
